// File: rtl/point_report_sched_if.sv
// point_report_sched_if: outbound point-report record stream (valid/ready)
// Parameters: CW channel-index width, W coordinate width.
// Signals: OUT_VALID/OUT_READY handshake; OUT_CH, OUT_H, OUT_V, OUT_TAG and
// OUT_LAST form the record payload.
// master: the scheduler driving records; slave: the report transmitter.
interface point_report_sched_if #(
  parameter int CW = 2,
  parameter int W  = 16
);
  logic          OUT_VALID;
  logic          OUT_READY;
  logic [CW-1:0] OUT_CH;
  logic [W-1:0]  OUT_H;
  logic [W-1:0]  OUT_V;
  logic [7:0]    OUT_TAG;
  logic          OUT_LAST;
  modport master (output OUT_VALID, OUT_CH, OUT_H, OUT_V, OUT_TAG, OUT_LAST, input OUT_READY);
  modport slave  (input OUT_VALID, OUT_CH, OUT_H, OUT_V, OUT_TAG, OUT_LAST, output OUT_READY);
endinterface

// File: rtl/point_report_sched.sv
// point_report_sched: frame-synchronous round-robin scheduler for point reports
// Ports: CLK/RST (sync, active-high); VGA_VS rising edge closes a frame;
// PT_VALID/PT_H/PT_V per-channel captures (channel c at [c*W +: W]);
// out: record stream (master); ERR sticky {frame skipped, capture overwrite}.
// Option: POINT_REPORT_DEDUP_EN suppresses channels whose coordinate repeats
// the last one reported for that channel.
module point_report_sched #(
  parameter int NCH = 4,
  parameter int W   = 16,
  parameter int CW  = $clog2(NCH)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  VGA_VS,
  input  logic [NCH-1:0]        PT_VALID,
  input  logic [NCH*W-1:0]      PT_H,
  input  logic [NCH*W-1:0]      PT_V,
  point_report_sched_if.master  out,
  output logic [1:0]            ERR
);
  typedef enum logic [1:0] {IDLE, SCAN, SEND} state_t;
  state_t         state_q, state_d;
  logic           rvs_q;
  logic [NCH-1:0] pend_q, mask_q, dup;
  logic [W-1:0]   hold_h_q [NCH];
  logic [W-1:0]   hold_v_q [NCH];
  logic [W-1:0]   shadow_h_q [NCH];
  logic [W-1:0]   shadow_v_q [NCH];
  logic [7:0]     tag_q, snap_tag_q;
  logic [CW-1:0]  rr_q, sel, idx;
  logic [1:0]     err_q;
  logic           edge_w, snap, load, xfer;

  assign edge_w        = VGA_VS & ~rvs_q;
  assign snap          = edge_w & (state_q == IDLE);
  assign ERR           = err_q;
  assign out.OUT_VALID = state_q == SEND;

  // Descending scan so the last hit is the first set bit at or after rr_q.
  always_comb begin
    sel = rr_q;
    idx = rr_q;
    for (int i = NCH - 1; i >= 0; i--) begin
      idx = CW'((int'(rr_q) + i) % NCH);
      if (mask_q[idx]) sel = idx;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    xfer    = 1'b0;
    case (state_q)
      IDLE: state_d = edge_w ? SCAN : IDLE;
      SCAN: begin
        load    = |mask_q;
        state_d = load ? SEND : IDLE;
      end
      SEND: begin
        xfer    = out.OUT_READY;
        state_d = xfer ? SCAN : SEND;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef POINT_REPORT_DEDUP_EN
  logic [W-1:0]   last_h_q [NCH];
  logic [W-1:0]   last_v_q [NCH];
  logic [NCH-1:0] last_ok_q;

  // last_ok_q keeps a never-reported channel from matching a zero coordinate.
  always_comb begin
    dup = '0;
    for (int c = 0; c < NCH; c++)
      dup[c] = last_ok_q[c] && hold_h_q[c] == last_h_q[c] && hold_v_q[c] == last_v_q[c];
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      last_ok_q <= '0;
      for (int c = 0; c < NCH; c++) begin
        last_h_q[c] <= '0;
        last_v_q[c] <= '0;
      end
    end else if (xfer) begin
      last_ok_q[sel] <= 1'b1;
      last_h_q[sel]  <= out.OUT_H;
      last_v_q[sel]  <= out.OUT_V;
    end
  end
`else
  assign dup = '0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      rvs_q        <= 1'b0;
      pend_q       <= '0;
      mask_q       <= '0;
      tag_q        <= '0;
      snap_tag_q   <= '0;
      rr_q         <= '0;
      err_q        <= '0;
      out.OUT_CH   <= '0;
      out.OUT_H    <= '0;
      out.OUT_V    <= '0;
      out.OUT_TAG  <= '0;
      out.OUT_LAST <= 1'b0;
      for (int c = 0; c < NCH; c++) begin
        hold_h_q[c]   <= '0;
        hold_v_q[c]   <= '0;
        shadow_h_q[c] <= '0;
        shadow_v_q[c] <= '0;
      end
    end else begin
      rvs_q <= VGA_VS;
      if (edge_w) tag_q <= tag_q + 8'd1;
      if (snap) snap_tag_q <= tag_q + 8'd1;
      if (edge_w && !snap) err_q[1] <= 1'b1;
      if (|(PT_VALID & pend_q) && !edge_w) err_q[0] <= 1'b1;
      // Captures coincident with the snapshot open the next frame's pending set.
      pend_q <= snap ? PT_VALID : pend_q | PT_VALID;
      mask_q <= snap ? pend_q & ~dup : xfer ? mask_q & ~(NCH'(1) << sel) : mask_q;
      for (int c = 0; c < NCH; c++) begin
        if (PT_VALID[c]) begin
          hold_h_q[c] <= PT_H[c*W +: W];
          hold_v_q[c] <= PT_V[c*W +: W];
        end
        if (snap) begin
          shadow_h_q[c] <= hold_h_q[c];
          shadow_v_q[c] <= hold_v_q[c];
        end
      end
      if (load) begin
        out.OUT_CH   <= sel;
        out.OUT_H    <= shadow_h_q[sel];
        out.OUT_V    <= shadow_v_q[sel];
        out.OUT_TAG  <= snap_tag_q;
        out.OUT_LAST <= mask_q == (NCH'(1) << sel);
      end
      if (xfer) rr_q <= (sel == CW'(NCH - 1)) ? '0 : sel + 1'b1;
    end
  end
endmodule

// File: tb/tb_point_report_sched.sv
// tb_point_report_sched: randomized and directed checks against a frame-level reference model
module tb_point_report_sched;
  localparam int NCH = 4;
  localparam int W   = 16;
  localparam int CW  = 2;

  logic clk = 1'b0, rst = 1'b1, vs = 1'b0, rdy = 1'b0;
  logic [NCH-1:0]   pv  = '0;
  logic [NCH*W-1:0] ph  = '0;
  logic [NCH*W-1:0] pvv = '0;
  logic [1:0]       err;

  point_report_sched_if #(.CW(CW), .W(W)) bus();
  assign bus.OUT_READY = rdy;

  point_report_sched #(.NCH(NCH), .W(W), .CW(CW)) dut (
    .CLK(clk), .RST(rst), .VGA_VS(vs), .PT_VALID(pv), .PT_H(ph), .PT_V(pvv),
    .out(bus), .ERR(err)
  );

  always #5 clk = ~clk;

  typedef struct {int ch; int h; int v; int tag; bit last;} rec_t;
  rec_t q[$];
  rec_t lx;
  int   xcyc[$];
  int   xch[$];
  int   tests = 0, fails = 0, cyc = 0, free_cyc = 0;
  bit   m_rvs;
  bit [1:0] m_err;
  int   m_tag, m_rr;
  bit   m_pend[NCH];
  int   m_h[NCH], m_v[NCH];
  bit   m_lok[NCH];
  int   m_lh[NCH], m_lv[NCH];

  task automatic model_reset();
    q.delete();
    m_rvs = 0; m_err = 0; m_tag = 0; m_rr = 0; free_cyc = 0;
    for (int c = 0; c < NCH; c++) begin
      m_pend[c] = 0; m_lok[c] = 0;
    end
  endtask

  // A frame's records: pending channels in round-robin order starting at m_rr.
  task automatic snapshot();
    int last = -1;
    for (int i = 0; i < NCH; i++) begin
      int c = (m_rr + i) % NCH;
      bit dupe = 0;
`ifdef POINT_REPORT_DEDUP_EN
      dupe = m_lok[c] && m_lh[c] == m_h[c] && m_lv[c] == m_v[c];
`endif
      if (m_pend[c] && !dupe) begin
        q.push_back('{c, m_h[c], m_v[c], m_tag, 1'b0});
        last = c;
      end
    end
    if (last >= 0) begin
      q[q.size()-1].last = 1;
      m_rr = (last + 1) % NCH;
    end
    free_cyc = cyc + 2;
  endtask

  // One clock: scoreboard the transfer at this edge, advance the model, then check ERR/stability.
  task automatic step();
    logic          v0, l0;
    logic [CW-1:0] c0;
    logic [W-1:0]  h0, vv0;
    logic [7:0]    t0;
    bit xf, e, busy;
    v0 = bus.OUT_VALID; c0 = bus.OUT_CH; h0 = bus.OUT_H; vv0 = bus.OUT_V;
    t0 = bus.OUT_TAG; l0 = bus.OUT_LAST;
    xf = v0 && rdy && !rst;
    if (rst) model_reset();
    else begin
      busy = q.size() != 0 || cyc < free_cyc;
      if (xf) begin
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL xfer: unexpected record ch=%0d h=%0d, none required", c0, h0);
        end else begin
          if (c0 !== CW'(q[0].ch) || h0 !== W'(q[0].h) || vv0 !== W'(q[0].v) ||
              t0 !== 8'(q[0].tag) || l0 !== q[0].last) begin
            fails++;
            $display("FAIL record: got ch=%0d h=%0d v=%0d tag=%0d last=%0d, need ch=%0d h=%0d v=%0d tag=%0d last=%0d",
                     c0, h0, vv0, t0, l0, q[0].ch, q[0].h, q[0].v, q[0].tag, q[0].last);
          end
          lx = q.pop_front();
          m_lok[lx.ch] = 1; m_lh[lx.ch] = lx.h; m_lv[lx.ch] = lx.v;
        end
        free_cyc = cyc + 2;
        xcyc.push_back(cyc);
        xch.push_back(int'(c0));
      end
      e = vs && !m_rvs;
      m_rvs = vs;
      if (e) m_tag = (m_tag + 1) % 256;
      for (int c = 0; c < NCH; c++) if (pv[c] && m_pend[c] && !e) m_err[0] = 1;
      if (e && busy) m_err[1] = 1;
      if (e && !busy) begin
        snapshot();
        for (int c = 0; c < NCH; c++) m_pend[c] = 0;
      end
      for (int c = 0; c < NCH; c++)
        if (pv[c]) begin
          m_pend[c] = 1; m_h[c] = int'(ph[c*W +: W]); m_v[c] = int'(pvv[c*W +: W]);
        end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (!rst) begin
      tests++;
      if (err !== m_err) begin
        fails++;
        $display("FAIL err: got %b need %b at cycle %0d", err, m_err, cyc);
      end
      if (v0 && !xf) begin
        tests++;
        if (bus.OUT_VALID !== 1'b1 || bus.OUT_CH !== c0 || bus.OUT_H !== h0 ||
            bus.OUT_V !== vv0 || bus.OUT_TAG !== t0 || bus.OUT_LAST !== l0) begin
          fails++;
          $display("FAIL hold: valid=%b ch=%0d h=%0d changed without transfer (was ch=%0d h=%0d)",
                   bus.OUT_VALID, bus.OUT_CH, bus.OUT_H, c0, h0);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic cap(input int c, input int h, input int v);
    pv = '0; pv[c] = 1'b1;
    ph[c*W +: W] = W'(h); pvv[c*W +: W] = W'(v);
    step();
    pv = '0;
  endtask

  task automatic frame_edge();
    vs = 1'b1; step();
    vs = 1'b0; step();
  endtask

  task automatic drain();
    int n = 0;
    rdy = 1'b1; vs = 1'b0; pv = '0;
    while ((q.size() != 0 || cyc < free_cyc || bus.OUT_VALID) && n < 200) begin
      step(); n++;
    end
    tests++;
    if (n >= 200) begin
      fails++;
      $display("FAIL drain: timeout with %0d records outstanding, need 0", q.size());
    end
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!bus.OUT_VALID && n < 20) begin step(); n++; end
    tests++;
    if (!bus.OUT_VALID) begin
      fails++;
      $display("FAIL wait_valid: OUT_VALID=%b after %0d cycles, need 1", bus.OUT_VALID, n);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; vs = 1'b0; pv = '0; rdy = 1'b0;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if (bus.OUT_VALID !== 1'b0 || err !== 2'b00 || bus.OUT_CH !== '0 || bus.OUT_H !== '0 ||
        bus.OUT_V !== '0 || bus.OUT_TAG !== 8'd0 || bus.OUT_LAST !== 1'b0) begin
      fails++;
      $display("FAIL reset: valid=%b err=%b ch=%0d h=%0d v=%0d tag=%0d last=%b, need all 0",
               bus.OUT_VALID, err, bus.OUT_CH, bus.OUT_H, bus.OUT_V, bus.OUT_TAG, bus.OUT_LAST);
    end
  endtask

  task automatic test_single();
    int n = 0;
    cap(2, 100, 50);
    rdy = 1'b1; vs = 1'b1; step(); vs = 1'b0;
    while (!bus.OUT_VALID && n < 10) begin step(); n++; end
    tests++;
    if (n + 1 !== 2) begin
      fails++;
      $display("FAIL latency: OUT_VALID high %0d cycles after edge, need 2", n + 1);
    end
    tests++;
    if (bus.OUT_CH !== 2'd2 || bus.OUT_H !== 16'd100 || bus.OUT_V !== 16'd50 ||
        bus.OUT_TAG !== 8'd1 || bus.OUT_LAST !== 1'b1) begin
      fails++;
      $display("FAIL single: ch=%0d h=%0d v=%0d tag=%0d last=%b, need 2/100/50/1/1",
               bus.OUT_CH, bus.OUT_H, bus.OUT_V, bus.OUT_TAG, bus.OUT_LAST);
    end
    drain();
  endtask

  task automatic test_all4();
    do_reset();
    pv = 4'hF;
    for (int c = 0; c < NCH; c++) begin
      ph[c*W +: W] = W'(10 * (c + 1)); pvv[c*W +: W] = W'(c + 1);
    end
    step(); pv = '0;
    xcyc.delete(); xch.delete();
    frame_edge(); drain();
    tests++;
    if (xch.size() != 4 || xch[0] != 0 || xch[1] != 1 || xch[2] != 2 || xch[3] != 3) begin
      fails++;
      $display("FAIL order4: got %0d records, need channels 0,1,2,3", xch.size());
    end else begin
      tests++;
      if (xcyc[1] - xcyc[0] != 2 || xcyc[2] - xcyc[1] != 2 || xcyc[3] - xcyc[2] != 2) begin
        fails++;
        $display("FAIL spacing: gaps %0d %0d %0d, need 2 2 2",
                 xcyc[1] - xcyc[0], xcyc[2] - xcyc[1], xcyc[3] - xcyc[2]);
      end
    end
    cap(1, 7, 8); cap(0, 5, 6);
    xch.delete();
    frame_edge(); drain();
    tests++;
    if (xch.size() != 2 || xch[0] != 0 || xch[1] != 1) begin
      fails++;
      $display("FAIL order2: got %0d records first=%0d, need channels 0,1",
               xch.size(), xch.size() > 0 ? xch[0] : -1);
    end
  endtask

  task automatic test_stall();
    logic [W-1:0] h0;
    cap(3, 33, 3); cap(0, 44, 4);
    rdy = 1'b0; frame_edge(); wait_valid();
    h0 = bus.OUT_H;
    xcyc.delete();
    repeat (20) step();
    tests++;
    if (bus.OUT_VALID !== 1'b1 || bus.OUT_H !== h0 || xcyc.size() != 0) begin
      fails++;
      $display("FAIL stall: valid=%b h=%0d transfers=%0d, need 1/%0d/0",
               bus.OUT_VALID, bus.OUT_H, xcyc.size(), h0);
    end
    drain();
  endtask

  task automatic test_overwrite();
    do_reset();
    cap(1, 5, 1); step(); cap(1, 9, 2);
    tests++;
    if (err !== 2'b01) begin
      fails++;
      $display("FAIL overwrite_err: got %b need 01", err);
    end
    frame_edge(); drain();
    tests++;
    if (lx.h != 9) begin
      fails++;
      $display("FAIL overwrite_h: got %0d need 9", lx.h);
    end
    xch.delete();
    pv = '0; pv[1] = 1'b1; ph[1*W +: W] = 16'd77; vs = 1'b1; step();
    pv = '0; vs = 1'b0; drain();
    tests++;
    if (xch.size() != 0 || err !== 2'b01) begin
      fails++;
      $display("FAIL coincident: records=%0d err=%b, need 0 and 01", xch.size(), err);
    end
    frame_edge(); drain();
    tests++;
    if (xch.size() != 1 || lx.h != 77) begin
      fails++;
      $display("FAIL coincident_next: records=%0d h=%0d, need 1 and 77", xch.size(), lx.h);
    end
  endtask

  task automatic test_skip();
    do_reset();
    cap(0, 12, 13);
    rdy = 1'b0; frame_edge(); wait_valid();
    xch.delete();
    frame_edge();
    tests++;
    if (err !== 2'b10 || bus.OUT_VALID !== 1'b1) begin
      fails++;
      $display("FAIL skip: err=%b valid=%b, need 10 and 1", err, bus.OUT_VALID);
    end
    drain();
    tests++;
    if (xch.size() != 1 || lx.tag != 1) begin
      fails++;
      $display("FAIL skip_frame: records=%0d tag=%0d, need 1 and 1", xch.size(), lx.tag);
    end
    cap(2, 1, 1); frame_edge(); drain();
    tests++;
    if (lx.tag != 3) begin
      fails++;
      $display("FAIL skip_tag: got %0d need 3", lx.tag);
    end
  endtask

  task automatic test_dedup();
    int need;
    do_reset();
    cap(0, 100, 50); frame_edge(); drain();
    xch.delete();
    cap(0, 100, 50); frame_edge(); drain();
`ifdef POINT_REPORT_DEDUP_EN
    need = 0;
`else
    need = 1;
`endif
    tests++;
    if (xch.size() != need) begin
      fails++;
      $display("FAIL dedup: second frame records=%0d need %0d", xch.size(), need);
    end
  endtask

  task automatic test_rst_mid_send();
    cap(1, 3, 3); rdy = 1'b0; frame_edge(); wait_valid();
    rst = 1'b1; step(); rst = 1'b0;
    tests++;
    if (bus.OUT_VALID !== 1'b0) begin
      fails++;
      $display("FAIL rst_send: valid=%b need 0", bus.OUT_VALID);
    end
    step();
  endtask

  task automatic test_random();
    for (int f = 0; f < 60; f++) begin
      int ncap = $urandom_range(0, 5);
      for (int k = 0; k < ncap; k++) begin
        pv = NCH'($urandom);
        for (int c = 0; c < NCH; c++) begin
          ph[c*W +: W] = W'($urandom_range(0, 3)); pvv[c*W +: W] = W'($urandom_range(0, 3));
        end
        rdy = $urandom_range(0, 3) != 0;
        step();
      end
      pv = ($urandom_range(0, 3) == 0) ? NCH'($urandom) : '0;
      vs = 1'b1; rdy = $urandom_range(0, 3) != 0; step();
      vs = 1'b0; pv = '0;
      repeat ($urandom_range(0, 8)) begin
        rdy = $urandom_range(0, 3) != 0; step();
      end
    end
    drain();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_all4();
    test_stall();
    test_overwrite();
    test_skip();
    test_dedup();
    test_rst_mid_send();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/point_report_sched.md
# point_report_sched

Frame-synchronous scheduler that shares one outbound point-report channel (UART/host packetizer) among NCH point-finder instances. Each finder delivers at most one (H, V) marker coordinate per frame. This block buffers the coordinates, snapshots them at the VGA_VS rising edge, and serializes them round-robin onto a single valid/ready stream tagged with the channel index and frame count. It sits between the per-marker point finders and the report transmitter.

## Interface
Parameters:
- NCH, 4: number of point-finder channels (2..8)
- W, 16: coordinate width
- CW, $clog2(NCH): channel-index width

Ports:
- CLK  in  1  pixel/system clock, all logic on posedge
- RST  in  1  synchronous reset, active-high
- VGA_VS  in  1  vertical sync; its rising edge closes a frame
- PT_VALID  in  NCH  per-channel one-cycle pulse, coordinate available
- PT_H  in  NCH*W  packed H coordinates, channel c at [c*W +: W]
- PT_V  in  NCH*W  packed V coordinates, same packing
- OUT_VALID  out  1  record valid
- OUT_READY  in  1  consumer accepts record
- OUT_CH  out  CW  channel index of record
- OUT_H / OUT_V  out  W  coordinate of record
- OUT_TAG  out  8  frame tag
- OUT_LAST  out  1  record is the last of its frame
- ERR  out  2  sticky: [0] capture overwrite, [1] frame skipped

## Operation
- Reset clears all outputs, rVS, PEND, MASK, HOLD, SHADOW, TAG, RR and ERR to 0. State is IDLE.
- Edge: EDGE = VGA_VS & ~rVS. rVS <= VGA_VS every cycle.
- Capture: PT_VALID[c] writes HOLD_H/V[c] <= PT_H/V slice and sets PEND[c]. If PEND[c] is already 1 and EDGE=0 in the same cycle, the data is overwritten and ERR[0] <= 1.
- Snapshot, on EDGE in IDLE:
  - SHADOW <= HOLD, MASK <= PEND, PEND <= PT_VALID.
  - A same-cycle capture belongs to the next frame and does not set ERR[0].
- TAG increments by 1 (mod 256) on every EDGE, in any state. Records carry the TAG value from the snapshot.
- EDGE in SCAN/SEND: no snapshot, PEND and HOLD untouched, ERR[1] <= 1.
- FSM:
  - IDLE: EDGE -> SCAN.
  - SCAN, MASK==0 -> IDLE.
  - SCAN, MASK!=0: select the first set bit searching from RR upward with wrap. Load OUT_CH/H/V/TAG from SHADOW. OUT_LAST = (MASK has exactly that bit set). -> SEND.
  - SEND: OUT_VALID=1. Output fields are held stable until OUT_VALID & OUT_READY. On transfer: clear MASK[sel], RR <= sel+1 (wrap at NCH), -> SCAN.
- RR persists across frames.
- ERR bits are cleared only by RST.

## Timing
- EDGE evaluated at posedge t puts the state in SCAN at t+1. OUT_VALID=1 from t+2.
- Transfer at posedge k deasserts OUT_VALID at k+1 (SCAN bubble). The next record is valid from k+2. Throughput is one record per 2 cycles with OUT_READY=1.
- OUT_VALID never drops without a transfer, except on RST.
- An empty frame (MASK==0) produces no records and returns to IDLE at t+2.
- OUT_LAST is valid whenever OUT_VALID=1.
- RST mid-SEND drops OUT_VALID the next cycle. The pending record is discarded.

## Configuration
- POINT_REPORT_DEDUP_EN defined:
  - At snapshot, any channel whose SHADOW H/V equals the previously reported H/V for that channel is removed from MASK.
  - A per-channel "last sent" register is updated on transfer and cleared by RST.
- Not defined: every pending channel is reported each frame. No last-sent registers.

## Test plan
- RST, NCH=4, PT_VALID[2] with H=100 V=50, then EDGE, OUT_READY=1 -> one record: CH=2, H=100, V=50, TAG=1, LAST=1, OUT_VALID first high 2 cycles after EDGE.
- All 4 channels captured (H=10,20,30,40), OUT_READY=1 -> records CH 0,1,2,3 at 2-cycle spacing; LAST only on CH=3. Next frame with channels 0 and 1 pending -> RR=0, order 0 then 1.
- OUT_READY held 0 for 20 cycles -> OUT_VALID and all fields stable; first transfer after OUT_READY rises.
- Two PT_VALID[1] pulses (H=5 then H=9) before EDGE -> reported H=9, ERR=2'b01. PT_VALID[1] coincident with EDGE -> not in this frame, ERR unchanged.
- Second EDGE while in SEND with OUT_READY=0 -> ERR[1]=1, TAG increments, current frame completes, no snapshot taken.
- With POINT_REPORT_DEDUP_EN, same (100,50) on ch0 for two frames -> second frame produces no record; without the macro -> two records.
